// File: rtl/prom_func_pkg.sv
// Shared types and helpers for the programmable-ROM function generator.
// Holds the FSM state enum and the INIT_TABLE entry extractor.
package prom_func_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Widest INIT_TABLE / entry the helper accepts; callers zero-extend into it.
  localparam int MAX_INIT_W = 1024;
  localparam int MAX_OUT_W  = 32;

  // Entry idx of a packed table whose entries are out_w bits wide, entry 0 in the LSBs.
  function automatic logic [MAX_OUT_W-1:0] init_entry(input logic [MAX_INIT_W-1:0] tbl,
                                                      input int idx,
                                                      input int out_w);
    logic [MAX_INIT_W-1:0] shifted;
    logic [MAX_OUT_W-1:0]  mask;
    shifted = tbl >> (idx * out_w);
    mask    = (MAX_OUT_W'(1) << out_w) - MAX_OUT_W'(1);
    return shifted[MAX_OUT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/prom_func_gen_if.sv
// Lookup, program and clear signals of prom_func_gen bundled as one interface.
// master = the controller driving requests, slave = the function generator.
interface prom_func_gen_if #(
  parameter int ADDR_W = 2,
  parameter int OUT_W  = 2
);

  logic              en;
  logic [ADDR_W-1:0] x;
  logic [OUT_W-1:0]  y;
  logic              y_valid;

  logic              prog_valid;
  logic              prog_ready;
  logic [ADDR_W-1:0] prog_addr;
  logic [OUT_W-1:0]  prog_data;
  logic              prog_err;

  logic              clr_req;
  logic              busy;

  modport master (
    output en, x, prog_valid, prog_addr, prog_data, clr_req,
    input  y, y_valid, prog_ready, prog_err, busy
  );

  modport slave (
    input  en, x, prog_valid, prog_addr, prog_data, clr_req,
    output y, y_valid, prog_ready, prog_err, busy
  );

endinterface

// File: rtl/prom_func_gen.sv
// Programmable-ROM function generator: registered 2^ADDR_W x OUT_W table lookup with
// program port and clear sequencer. Optional write-once locking under `PROM_LOCK_EN.
module prom_func_gen
  import prom_func_pkg::*;
#(
  parameter int                             ADDR_W     = 2,
  parameter int                             OUT_W      = 2,
  parameter logic [(2**ADDR_W)*OUT_W-1:0]   INIT_TABLE = 8'h9E
) (
  input  logic             clk,
  input  logic             rst_n,
  prom_func_gen_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               busy_q;
  logic [OUT_W-1:0]   y_q;
  logic               y_valid_q;
  logic [OUT_W-1:0]   tbl_q    [DEPTH];
  logic [OUT_W-1:0]   init_mem [DEPTH];

  logic prog_ready;
  logic wr_fire;
  logic lookup_fire;
  logic clr_last;
  logic wr_blocked;

  // Constant-only network: the reset image and the clear source are the same values.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      init_mem[k] = OUT_W'(init_entry(MAX_INIT_W'(INIT_TABLE), k, OUT_W));
    end
  end

`ifdef PROM_LOCK_EN
  logic [DEPTH-1:0] locked_q;
  logic             prog_err_q;
`endif

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    prog_ready  = (state_q == IDLE) && !bus.clr_req;
    wr_fire     = bus.prog_valid && prog_ready;
    lookup_fire = (state_q == IDLE) && bus.en;
    cnt_d       = cnt_q + CNT_W'(1);
    clr_last    = (cnt_q == CNT_W'(DEPTH - 1));
`ifdef PROM_LOCK_EN
    wr_blocked  = locked_q[bus.prog_addr];
`else
    wr_blocked  = 1'b0;
`endif
  end

  // NOTE: the table is register-based, so it is reset to INIT_TABLE like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        tbl_q[k] <= init_mem[k];
      end
`ifdef PROM_LOCK_EN
      locked_q   <= '0;
      prog_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignment makes a same-edge lookup see the pre-write entry.
      y_valid_q <= lookup_fire;
      if (lookup_fire) begin
        y_q <= tbl_q[bus.x];
      end
`ifdef PROM_LOCK_EN
      prog_err_q <= wr_fire && wr_blocked;
`endif

      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else if (wr_fire && !wr_blocked) begin
            tbl_q[bus.prog_addr] <= bus.prog_data;
`ifdef PROM_LOCK_EN
            locked_q[bus.prog_addr] <= 1'b1;
`endif
          end
        end

        CLEAR: begin
          tbl_q[cnt_q[ADDR_W-1:0]] <= init_mem[cnt_q[ADDR_W-1:0]];
`ifdef PROM_LOCK_EN
          locked_q[cnt_q[ADDR_W-1:0]] <= 1'b0;
`endif
          cnt_q <= cnt_d;
          if (clr_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.y          = y_q;
  assign bus.y_valid    = y_valid_q;
  assign bus.prog_ready = prog_ready;
  assign bus.busy       = busy_q;
`ifdef PROM_LOCK_EN
  assign bus.prog_err   = prog_err_q;
`else
  assign bus.prog_err   = 1'b0;
`endif

endmodule

// File: tb/tb_prom_func_gen.sv
// Scoreboard bench for prom_func_gen: directed scenarios plus random traffic against a
// table-level reference model. Honours `PROM_LOCK_EN in the model.
module tb_prom_func_gen;

  localparam int ADDR_W = 2;
  localparam int OUT_W  = 2;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;

  prom_func_gen_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

  prom_func_gen #(.ADDR_W(ADDR_W), .OUT_W(OUT_W), .INIT_TABLE(8'h9E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default image {10,01,11,10} listed entry3..0, so entry0 = 10.
  logic [OUT_W-1:0] init_vals [DEPTH] = '{2'b10, 2'b11, 2'b01, 2'b10};

  // Reference model state
  logic [OUT_W-1:0] m_tbl  [DEPTH];
  bit               m_lock [DEPTH];
  int               clear_left;
  logic [OUT_W-1:0] exp_y;
  logic             exp_valid;
  logic             exp_err;
  logic             exp_busy;
  logic [OUT_W-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m_tbl[k]  = init_vals[k];
      m_lock[k] = 1'b0;
    end
    clear_left = 0;
    exp_y      = '0;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
    exp_busy   = 1'b0;
    exp_q.delete();
  endtask

  // Applies one rising edge worth of behaviour using the inputs presented for it.
  task automatic model_step();
    int idx;
    exp_err = 1'b0;
    if (clear_left > 0) begin
      idx         = DEPTH - clear_left;
      m_tbl[idx]  = init_vals[idx];
      m_lock[idx] = 1'b0;
      clear_left--;
      exp_valid   = 1'b0;
    end else begin
      if (bus.en) begin
        exp_q.push_back(m_tbl[bus.x]);
        exp_y     = m_tbl[bus.x];
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (bus.clr_req) begin
        clear_left = DEPTH;
      end else if (bus.prog_valid) begin
`ifdef PROM_LOCK_EN
        if (m_lock[bus.prog_addr]) begin
          exp_err = 1'b1;
        end else begin
          m_tbl[bus.prog_addr]  = bus.prog_data;
          m_lock[bus.prog_addr] = 1'b1;
        end
`else
        m_tbl[bus.prog_addr] = bus.prog_data;
`endif
      end
    end
    exp_busy = (clear_left > 0);
  endtask

  task automatic drive(input logic e, input logic [ADDR_W-1:0] xa, input logic pv,
                       input logic [ADDR_W-1:0] pa, input logic [OUT_W-1:0] pd,
                       input logic cr);
    bus.en         = e;
    bus.x          = xa;
    bus.prog_valid = pv;
    bus.prog_addr  = pa;
    bus.prog_data  = pd;
    bus.clr_req    = cr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard whenever y_valid is seen.
  always @(negedge clk) begin
    logic [OUT_W-1:0] e;
    check("y_valid", bus.y_valid, exp_valid);
    if (bus.y_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL y_unexpected: got y_valid=1 expected no pending lookup at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("y", bus.y, e);
      end
    end else begin
      check("y_hold", bus.y, exp_y);
    end
    check("busy", bus.busy, exp_busy);
    check("prog_err", bus.prog_err, exp_err);
    check("prog_ready", bus.prog_ready, (clear_left == 0) && !bus.clr_req);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.en         = 1'b0;
    bus.x          = '0;
    bus.prog_valid = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = '0;
    bus.clr_req    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back lookups of every entry, then en low for 3 cycles.
    for (int k = 0; k < DEPTH; k++) drive(1'b1, ADDR_W'(k), 1'b0, '0, '0, 1'b0);
    idle(3);

    // Read-before-write on the same address, then the new value.
    drive(1'b1, 2'd2, 1'b1, 2'd2, 2'b11, 1'b0);
    drive(1'b1, 2'd2, 1'b0, '0, '0, 1'b0);

    // Clear beats a simultaneous write; requests during CLEAR are ignored.
    drive(1'b0, '0, 1'b1, 2'd0, 2'b00, 1'b1);
    drive(1'b1, 2'd1, 1'b1, 2'd1, 2'b00, 1'b1);
    drive(1'b1, 2'd3, 1'b1, 2'd3, 2'b00, 1'b0);
    idle(2);
    for (int k = 0; k < DEPTH; k++) drive(1'b1, ADDR_W'(k), 1'b0, '0, '0, 1'b0);

    // Reset in the second CLEAR cycle after zeroing every entry.
    for (int k = 0; k < DEPTH; k++) drive(1'b0, '0, 1'b1, ADDR_W'(k), 2'b00, 1'b0);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) drive(1'b1, ADDR_W'(k), 1'b0, '0, '0, 1'b0);
    idle(1);

    // Write-once behaviour (or plain rewrite when locking is not built in).
    drive(1'b0, '0, 1'b1, 2'd1, 2'b00, 1'b0);
    drive(1'b0, '0, 1'b1, 2'd1, 2'b01, 1'b0);
    drive(1'b1, 2'd1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(DEPTH);
    drive(1'b0, '0, 1'b1, 2'd1, 2'b01, 1'b0);
    drive(1'b1, 2'd1, 1'b0, '0, '0, 1'b0);
    idle(2);

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
            1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
            OUT_W'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end
    idle(DEPTH + 2);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
